// File: rtl/udp_line2bram.sv
// Unpacks one video line per UDP payload (2-byte line number + RGB triplets) into
// 24-bit pixel writes to the frame BRAM at line*H_PIX + pixel.
module udp_line2bram #(
    parameter int unsigned H_PIX   = 320,
    parameter int unsigned V_LINES = 180,
    parameter int unsigned ADDR_W  = 20
) (
    input  logic              clk,
    input  logic              xrst,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    input  logic              rx_sof,
    input  logic              rx_eof,
    output logic              bram_we,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [23:0]       bram_wdata,
    output logic              line_done,
    output logic              frame_done,
    output logic [7:0]        err_cnt
);

    localparam int unsigned PIX_W = $clog2(H_PIX + 1);

    typedef enum logic [1:0] {StIdle, StHdrLo, StPixel, StDrop} state_t;

    state_t              st_q, st_d;
    logic [15:0]         line_q, line_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [PIX_W-1:0]    pix_q, pix_d;
    logic [1:0]          phase_q, phase_d;
    logic [7:0]          r_q, r_d, g_q, g_d;
    logic                drop_err_q, drop_err_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [23:0]         wdata_q, wdata_d;
    logic                pend_q, pend_d, pend_frame_q, pend_frame_d;
    logic                line_done_q, frame_done_q;
    logic [7:0]          err_cnt_q;
    logic                err_inc;
    logic [15:0]         hdr_line;
    logic                last_b;

    // Constant multiply by H_PIX as a sum of shifted copies, one per set bit.
    function automatic logic [ADDR_W-1:0] mul_hpix(input logic [15:0] l);
        logic [ADDR_W-1:0] acc;
        acc = '0;
        for (int i = 0; i < 32; i++) begin
            if (H_PIX[i]) acc = acc + (ADDR_W'(l) << i);
        end
        return acc;
    endfunction

    assign hdr_line = {line_q[15:8], rx_data};
    assign last_b   = (phase_q == 2'd2) && (pix_q == PIX_W'(H_PIX - 1));

    always_comb begin
        st_d         = st_q;
        line_d       = line_q;
        base_d       = base_q;
        pix_d        = pix_q;
        phase_d      = phase_q;
        r_d          = r_q;
        g_d          = g_q;
        drop_err_d   = drop_err_q;
        we_d         = 1'b0;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        pend_d       = 1'b0;
        pend_frame_d = 1'b0;
        err_inc      = 1'b0;
        if (rx_valid) begin
            if (rx_sof) begin
                // sof anywhere restarts; outside IDLE it also aborts the packet in flight
                if (st_q != StIdle) err_inc = 1'b1;
                if (rx_eof) begin
                    err_inc = 1'b1;
                    st_d    = StIdle;
                end else begin
                    line_d[15:8] = rx_data;
                    st_d         = StHdrLo;
                end
            end else begin
                unique case (st_q)
                    StIdle: begin
                    end
                    StHdrLo: begin
                        line_d[7:0] = rx_data;
                        if (rx_eof) begin
                            err_inc = 1'b1;
                            st_d    = StIdle;
                        end else if (hdr_line >= 16'(V_LINES)) begin
                            err_inc    = 1'b1;
                            drop_err_d = 1'b0;
                            st_d       = StDrop;
                        end else begin
                            base_d  = mul_hpix(hdr_line);
                            pix_d   = '0;
                            phase_d = 2'd0;
                            st_d    = StPixel;
                        end
                    end
                    StPixel: begin
                        case (phase_q)
                            2'd0: begin
                                r_d     = rx_data;
                                phase_d = 2'd1;
                            end
                            2'd1: begin
                                g_d     = rx_data;
                                phase_d = 2'd2;
                            end
                            default: begin
                                we_d    = 1'b1;
                                addr_d  = base_q + ADDR_W'(pix_q);
                                wdata_d = {r_q, g_q, rx_data};
                                phase_d = 2'd0;
                                pix_d   = pix_q + 1'b1;
                            end
                        endcase
                        if (rx_eof) begin
                            st_d = StIdle;
                            if (last_b) begin
                                pend_d       = 1'b1;
                                pend_frame_d = (line_q == 16'(V_LINES - 1));
                            end else begin
                                err_inc = 1'b1;
                            end
                        end else if (last_b) begin
                            drop_err_d = 1'b1;
                            st_d       = StDrop;
                        end
                    end
                    StDrop: begin
                        if (rx_eof) begin
                            if (drop_err_q) err_inc = 1'b1;
                            st_d = StIdle;
                        end
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            st_q         <= StIdle;
            line_q       <= '0;
            base_q       <= '0;
            pix_q        <= '0;
            phase_q      <= '0;
            r_q          <= '0;
            g_q          <= '0;
            drop_err_q   <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            pend_q       <= 1'b0;
            pend_frame_q <= 1'b0;
            line_done_q  <= 1'b0;
            frame_done_q <= 1'b0;
            err_cnt_q    <= '0;
        end else begin
            st_q         <= st_d;
            line_q       <= line_d;
            base_q       <= base_d;
            pix_q        <= pix_d;
            phase_q      <= phase_d;
            r_q          <= r_d;
            g_q          <= g_d;
            drop_err_q   <= drop_err_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            pend_q       <= pend_d;
            pend_frame_q <= pend_frame_d;
            // Done pulses trail the final write strobe by one cycle
            line_done_q  <= pend_q;
            frame_done_q <= pend_frame_q;
            if (err_inc && (err_cnt_q != 8'hFF)) err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    assign bram_we    = we_q;
    assign bram_addr  = addr_q;
    assign bram_wdata = wdata_q;
    assign line_done  = line_done_q;
    assign frame_done = frame_done_q;
    assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_udp_line2bram.sv
// Bench for udp_line2bram: random payloads checked against a packet-level model of the
// expected BRAM writes, error count and done pulses.
module tb_udp_line2bram;

    localparam int H  = 320;
    localparam int V  = 180;
    localparam int AW = 20;

    logic          clk = 1'b0;
    logic          xrst = 1'b0;
    logic [7:0]    rx_data = '0;
    logic          rx_valid = 1'b0, rx_sof = 1'b0, rx_eof = 1'b0;
    logic          bram_we;
    logic [AW-1:0] bram_addr;
    logic [23:0]   bram_wdata;
    logic          line_done, frame_done;
    logic [7:0]    err_cnt;

    udp_line2bram #(.H_PIX(H), .V_LINES(V), .ADDR_W(AW)) dut (
        .clk        (clk),
        .xrst       (xrst),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_sof     (rx_sof),
        .rx_eof     (rx_eof),
        .bram_we    (bram_we),
        .bram_addr  (bram_addr),
        .bram_wdata (bram_wdata),
        .line_done  (line_done),
        .frame_done (frame_done),
        .err_cnt    (err_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [AW-1:0] wr_addr[$];
    logic [23:0]   wr_data[$];
    int            wr_cyc[$], ld_cyc[$], fd_cyc[$];

    int            exp_addr[$];
    logic [23:0]   exp_data[$];
    int            exp_err = 0, exp_ld = 0, exp_fd = 0;

    logic [7:0]    pkt[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bram_we) begin
            wr_addr.push_back(bram_addr);
            wr_data.push_back(bram_wdata);
            wr_cyc.push_back(cyc);
        end
        if (line_done) ld_cyc.push_back(cyc);
        if (frame_done) fd_cyc.push_back(cyc);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Payload: line number then pixel bytes; patterned pixels are {k[7:0],55,AA}.
    task automatic make_pkt(input int line, input int nbytes, input bit patterned);
        int k;
        pkt.delete();
        pkt.push_back(8'(line >> 8));
        pkt.push_back(8'(line));
        for (int i = 0; i < nbytes - 2; i++) begin
            k = i / 3;
            if (!patterned) pkt.push_back(8'($urandom));
            else if (i % 3 == 0) pkt.push_back(8'(k));
            else if (i % 3 == 1) pkt.push_back(8'h55);
            else pkt.push_back(8'hAA);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            rx_valid = 1'b0;
            rx_data  = 8'($urandom);
            rx_sof   = 1'($urandom_range(0, 1));
            rx_eof   = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
        end
        rx_sof = 1'b0;
        rx_eof = 1'b0;
    endtask

    task automatic send(input int from, input int to, input bit sof_first, input bit eof_last,
                        input bit gaps);
        for (int i = from; i < to; i++) begin
            if (gaps && ($urandom_range(0, 3) == 0)) idle($urandom_range(1, 3));
            rx_valid = 1'b1;
            rx_data  = pkt[i];
            rx_sof   = sof_first && (i == from);
            rx_eof   = eof_last && (i == to - 1);
            @(posedge clk);
            #1;
        end
        rx_valid = 1'b0;
        rx_sof   = 1'b0;
        rx_eof   = 1'b0;
    endtask

    // Expected effect of the first n bytes of pkt. kind: 0 ends with eof, 1 cut by a new
    // sof, 2 cut by reset (writes only).
    task automatic model(input int n, input int kind);
        int line, npix;
        if (n < 2) begin
            exp_err++;
            return;
        end
        if (n == 2 && kind == 0) begin
            exp_err++;
            return;
        end
        line = {16'd0, pkt[0], pkt[1]};
        if (line >= V) begin
            if (kind != 2) exp_err += (kind == 0) ? 1 : 2;
            return;
        end
        npix = (n - 2) / 3;
        if (npix > H) npix = H;
        for (int k = 0; k < npix; k++) begin
            exp_addr.push_back(line * H + k);
            exp_data.push_back({pkt[2 + 3 * k], pkt[3 + 3 * k], pkt[4 + 3 * k]});
        end
        if (kind == 1) exp_err++;
        else if (kind == 0) begin
            if (n - 2 == 3 * H) begin
                exp_ld++;
                if (line == V - 1) exp_fd++;
            end else begin
                exp_err++;
            end
        end
    endtask

    task automatic compare(input string tag);
        int m;
        check({tag, "_nwr"}, 32'(wr_addr.size()), 32'(exp_addr.size()));
        m = (wr_addr.size() < exp_addr.size()) ? wr_addr.size() : exp_addr.size();
        for (int i = 0; i < m; i++) begin
            check($sformatf("%s_addr%0d", tag, i), 32'(wr_addr[i]), exp_addr[i]);
            check($sformatf("%s_data%0d", tag, i), 32'(wr_data[i]), 32'(exp_data[i]));
        end
        check({tag, "_err"}, 32'(err_cnt), exp_err);
        check({tag, "_nld"}, 32'(ld_cyc.size()), exp_ld);
        check({tag, "_nfd"}, 32'(fd_cyc.size()), exp_fd);
        if (exp_ld > 0 && ld_cyc.size() > 0 && wr_cyc.size() > 0)
            check({tag, "_ld_lat"}, ld_cyc[ld_cyc.size() - 1], wr_cyc[wr_cyc.size() - 1] + 1);
        if (exp_fd > 0 && fd_cyc.size() > 0 && ld_cyc.size() > 0)
            check({tag, "_fd_ld"}, fd_cyc[0], ld_cyc[ld_cyc.size() - 1]);
        wr_addr.delete();
        wr_data.delete();
        wr_cyc.delete();
        ld_cyc.delete();
        fd_cyc.delete();
        exp_addr.delete();
        exp_data.delete();
        exp_ld = 0;
        exp_fd = 0;
    endtask

    task automatic do_reset();
        xrst = 1'b0;
        idle(2);
        xrst    = 1'b1;
        exp_err = 0;
        idle(1);
    endtask

    initial begin
        #1;
        check("rst_we", 32'(bram_we), 0);
        check("rst_addr", 32'(bram_addr), 0);
        check("rst_wdata", 32'(bram_wdata), 0);
        check("rst_ld", 32'(line_done), 0);
        check("rst_fd", 32'(frame_done), 0);
        check("rst_err", 32'(err_cnt), 0);
        idle(2);
        xrst = 1'b1;
        idle(1);

        // Full line 0, back-to-back, patterned pixels
        make_pkt(0, 962, 1'b1);
        send(0, 962, 1'b1, 1'b1, 1'b0);
        model(962, 0);
        idle(4);
        compare("t1");

        // Last line with random gaps: line_done and frame_done together
        do_reset();
        make_pkt(179, 962, 1'b0);
        send(0, 962, 1'b1, 1'b1, 1'b1);
        model(962, 0);
        idle(4);
        compare("t2");

        // Out-of-range line dropped; sof-less bytes afterwards ignored
        do_reset();
        make_pkt(180, 962, 1'b0);
        send(0, 962, 1'b1, 1'b1, 1'b0);
        model(962, 0);
        send(0, 962, 1'b0, 1'b1, 1'b0);
        idle(4);
        compare("t3");

        // Early eof after 10 pixels and one stray byte
        do_reset();
        make_pkt(5, 962, 1'b0);
        send(0, 33, 1'b1, 1'b1, 1'b0);
        model(33, 0);
        idle(4);
        compare("t4");

        // Line 7 aborted by sof after 4 pixels, then a full line 8
        do_reset();
        make_pkt(7, 962, 1'b0);
        send(0, 14, 1'b1, 1'b0, 1'b0);
        model(14, 1);
        make_pkt(8, 962, 1'b0);
        send(0, 962, 1'b1, 1'b1, 1'b1);
        model(962, 0);
        idle(4);
        compare("t5");

        // 1-byte payload, then reset in the middle of line 3
        do_reset();
        make_pkt(3, 962, 1'b0);
        send(0, 1, 1'b1, 1'b1, 1'b0);
        model(1, 0);
        idle(3);
        compare("t6a");
        make_pkt(3, 962, 1'b0);
        send(0, 17, 1'b1, 1'b0, 1'b0);
        check("t6_we_pre", 32'(bram_we), 1);
        xrst = 1'b0;
        #1;
        check("t6_we_rst", 32'(bram_we), 0);
        check("t6_addr_rst", 32'(bram_addr), 0);
        check("t6_wdata_rst", 32'(bram_wdata), 0);
        check("t6_err_rst", 32'(err_cnt), 0);
        model(14, 2);
        exp_err = 0;
        compare("t6b");
        @(posedge clk);
        #1;
        xrst = 1'b1;
        send(17, 962, 1'b0, 1'b1, 1'b0);
        idle(3);
        send(0, 962, 1'b1, 1'b1, 1'b0);
        model(962, 0);
        idle(4);
        compare("t6c");

        // Three surplus bytes: full line written, error, no line_done
        do_reset();
        make_pkt(10, 965, 1'b0);
        send(0, 965, 1'b1, 1'b1, 1'b1);
        model(965, 0);
        idle(4);
        compare("t7");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
